// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO keeping pc and inst paired.
// Define FETCH_QUEUE_BYPASS_EN for a same-cycle bypass when the queue is empty.
module fetch_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_pc,
  input  logic [INST_W-1:0]         in_inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [INST_W-1:0]         out_inst,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              empty;
  logic              full;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              store;
  logic              advance;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with a consumer ready: hand the offered entry straight through.
  assign bypass = rst && !flush && empty && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !flush && (!empty || bypass);
  assign pop       = out_valid && out_ready;
  assign in_ready  = rst && !flush && (!full || pop);
  assign push      = in_valid && in_ready;
  assign store     = push && !bypass;
  assign advance   = pop && !bypass;
  assign count     = cnt;

  // Head presentation, masked to zero when nothing is valid.
  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (out_valid) begin
      if (bypass) begin
        out_pc   = in_pc;
        out_inst = in_inst;
      end else begin
        out_pc   = pc_mem[rd_ptr];
        out_inst = inst_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (advance) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(store) - CNT_W'(advance);
    end
  end

  // Storage is never cleared; stale slots stay hidden behind out_valid.
  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t            q[$];
  logic              e_in_ready, e_out_valid, e_push, e_pop, e_byp;
  logic [ADDR_W-1:0] e_pc;
  logic [INST_W-1:0] e_inst;

  fetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference behaviour from the handshake rules, using the queue occupancy.
  function automatic void model_expect();
    e_byp       = BYP && rst && !flush && (q.size() == 0) && in_valid && out_ready;
    e_out_valid = rst && !flush && ((q.size() > 0) || e_byp);
    e_pop       = e_out_valid && out_ready;
    e_in_ready  = rst && !flush && ((q.size() < DEPTH) || e_pop);
    e_push      = in_valid && e_in_ready;
    if (!e_out_valid) begin
      e_pc = '0; e_inst = '0;
    end else if (q.size() > 0) begin
      e_pc = q[0].pc; e_inst = q[0].inst;
    end else begin
      e_pc = in_pc; e_inst = in_inst;
    end
  endfunction

  function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
    return ~pc ^ 32'h5A5A_0000;
  endfunction

  // Apply inputs just after the falling edge, then refresh expectations.
  task automatic drive(input bit v, input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst,
                       input bit ordy, input bit fl);
    in_valid = v; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    #1;
    model_expect();
  endtask

  // Advance one clock and update the model with this cycle's handshakes.
  task automatic tick();
    entry_t e;
    model_expect();
    e.pc = in_pc; e.inst = in_inst;
    @(posedge clk);
    if (!rst || flush) q.delete();
    else begin
      if (e_pop && q.size() > 0) void'(q.pop_front());
      if (e_push && !e_byp) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(32'h1000 + i), inst_of(ADDR_W'(32'h1000)), 1'b1, 1'b0);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_pc !== '0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
      n_checks++; if (out_inst !== '0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
      n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      tick();
    end
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill4(input logic [ADDR_W-1:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, base + ADDR_W'(4*i), inst_of(base + ADDR_W'(4*i)), 1'b0, 1'b0);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
    end
  endtask

  task automatic test_fill();
    fill4(32'h100);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h999, 32'h0, 1'b0, 1'b0);
      n_checks++; if (count !== CNT_W'(4)) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", in_ready); end
      n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL fill_stall_pc[%0d]: got %h want 100", i, out_pc); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_pc !== ADDR_W'(32'h100 + 4*i)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h want %h", i, out_pc, 32'h100 + 4*i); end
      n_checks++; if (out_inst !== inst_of(ADDR_W'(32'h100 + 4*i))) begin n_fail++; $display("FAIL drain_inst[%0d]: got %h want %h", i, out_inst, inst_of(ADDR_W'(32'h100 + 4*i))); end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_full_push_pop();
    fill4(32'h100);
    drive(1'b1, 32'h110, inst_of(32'h110), 1'b1, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpp_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL fullpp_head: got %h want 100", out_pc); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== CNT_W'(4)) begin n_fail++; $display("FAIL fullpp_count: got %0d want 4", count); end
    // Drain while refilling so both pointers wrap more than once.
    for (int i = 0; i < 9; i++) begin
      drive(i < 5, ADDR_W'(32'h114 + 4*i), inst_of(ADDR_W'(32'h114 + 4*i)), 1'b1, 1'b0);
      n_checks++; if (out_pc !== ADDR_W'(32'h104 + 4*i)) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, out_pc, 32'h104 + 4*i); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d]: got %b want 1", i, out_valid); end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL wrap_count: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(32'h180 + 4*i), inst_of(ADDR_W'(32'h180 + 4*i)), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h200, inst_of(32'h200), 1'b1, 1'b1);
    n_checks++; if (count !== CNT_W'(3)) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      n_checks++; if (count !== '0) begin n_fail++; $display("FAIL flush_count[%0d]: got %0d want 0", i, count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_valid[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 32'h300, inst_of(32'h300), 1'b1, 1'b0);
    n_checks++; if (out_valid !== BYP) begin n_fail++; $display("FAIL lat_same_valid: got %b want %b", out_valid, BYP); end
    n_checks++; if (out_pc !== (BYP ? 32'h300 : 32'h0)) begin n_fail++; $display("FAIL lat_same_pc: got %h want %h", out_pc, BYP ? 32'h300 : 32'h0); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (count !== CNT_W'(BYP ? 0 : 1)) begin n_fail++; $display("FAIL lat_count: got %0d want %0d", count, BYP ? 0 : 1); end
    n_checks++; if (out_pc !== (BYP ? 32'h0 : 32'h300)) begin n_fail++; $display("FAIL lat_next_pc: got %h want %h", out_pc, BYP ? 32'h0 : 32'h300); end
    tick();
    drive(1'b1, 32'h340, inst_of(32'h340), 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_store_valid: got %b want 0", out_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (out_pc !== 32'h340) begin n_fail++; $display("FAIL stall_store_pc: got %h want 340", out_pc); end
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ADDR_W'(32'h380 + 4*i), inst_of(ADDR_W'(32'h380 + 4*i)), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_checks++; if (count !== CNT_W'(2)) begin n_fail++; $display("FAIL areset_pre_count: got %0d want 2", count); end
    rst = 1'b0;
    #1;
    q.delete();
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_pc !== '0) begin n_fail++; $display("FAIL areset_pc: got %h want 0", out_pc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h400, inst_of(32'h400), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (out_pc !== 32'h400) begin n_fail++; $display("FAIL areset_first_pc: got %h want 400", out_pc); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_first_valid: got %b want 1", out_valid); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom), INST_W'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      n_checks++; if (in_ready !== e_in_ready) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, e_in_ready); end
      n_checks++; if (out_valid !== e_out_valid) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", i, out_valid, e_out_valid); end
      n_checks++; if (out_pc !== e_pc) begin n_fail++; $display("FAIL rnd_out_pc[%0d]: got %h want %h", i, out_pc, e_pc); end
      n_checks++; if (out_inst !== e_inst) begin n_fail++; $display("FAIL rnd_out_inst[%0d]: got %h want %h", i, out_inst, e_inst); end
      n_checks++; if (count !== CNT_W'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, q.size()); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_full_push_pop();
    test_flush();
    test_latency();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32, width of the instruction address field.
REQ-002 Parameter INST_W, default 32, width of the instruction word field.
REQ-003 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous discard of all held and incoming entries.
REQ-008 in_valid  input  1  fetch stage offers {in_pc, in_inst} this cycle.
REQ-009 in_ready  output  1  queue accepts the offered entry this cycle.
REQ-010 in_pc  input  ADDR_W  address of the offered instruction.
REQ-011 in_inst  input  INST_W  offered instruction word.
REQ-012 out_valid  output  1  head entry presented to the decode stage.
REQ-013 out_ready  input  1  decode consumes the head entry; low means decode stalls.
REQ-014 out_pc  output  ADDR_W  head address; zero when out_valid=0.
REQ-015 out_inst  output  INST_W  head instruction; zero when out_valid=0.
REQ-016 count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 Entries SHALL leave in strict arrival order; pc and inst of one entry stay paired.
REQ-019 in_ready = !flush && (count < DEPTH || pop this cycle); a full queue accepts a push in the same cycle as a pop.
REQ-020 out_valid = !flush && (count > 0), except when bypass applies (REQ-032).
REQ-021 Simultaneous push and pop SHALL leave count unchanged.
REQ-022 Empty with push and no pop: entry becomes visible on out_* the next cycle (latency 1).
REQ-023 Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without loss.
REQ-024 flush=1: in that cycle out_valid=0 and in_ready=0; at the next edge count=0 and the pointers are equal; the entry offered in that cycle is dropped.
REQ-025 flush SHALL take priority over push, pop and bypass.
REQ-026 While out_valid=1 && out_ready=0, out_pc/out_inst SHALL hold stable.
REQ-027 Storage contents need not be cleared; stale entries are never visible because out_* are masked to zero when invalid.

Reset
REQ-028 rst=0 SHALL asynchronously set count=0 and both pointers=0, giving out_valid=0, out_pc=0 and out_inst=0.
REQ-029 While rst=0, in_ready=0.
REQ-030 Reset asserted mid-operation discards all entries; the first push after release is the first entry presented.
REQ-031 Release of rst is synchronised by the system; the block needs no internal synchroniser.

Configuration
REQ-032 With macro FETCH_QUEUE_BYPASS_EN defined: when count=0, in_valid=1, out_ready=1 and flush=0, in_pc/in_inst SHALL appear combinationally on out_* with out_valid=1 and SHALL NOT be stored (count stays 0).
REQ-033 With FETCH_QUEUE_BYPASS_EN defined, empty with in_valid=1 and out_ready=0 SHALL store the entry and present it as in REQ-020 (no bypass).
REQ-034 Without FETCH_QUEUE_BYPASS_EN, there is no combinational path from in_* to out_*, and minimum latency is 1 cycle in all cases.

Verification (DEPTH=4)
REQ-035 Reset: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_pc=0, out_inst=0, count=0.
REQ-036 Fill: push pc 0x100,0x104,0x108,0x10C with out_ready=0 -> count=4, in_ready=0, out_pc=0x100 held stable; then out_ready=1 -> pcs emerge in order 0x100..0x10C, one per cycle.
REQ-037 Full push and pop in the same cycle: count=4, push pc 0x110 with out_ready=1 -> count stays 4, in_ready=1 that cycle; 0x110 emerges fifth; check pointer wrap over 10 cycles.
REQ-038 Flush: count=3, flush=1 with in_valid=1 (pc 0x200) -> out_valid=0 that cycle; next cycle count=0; 0x200 never appears.
REQ-039 Bypass build: empty, in_valid=1, pc 0x300, out_ready=1 -> out_pc=0x300, out_valid=1 same cycle, count=0; non-bypass build -> out_pc=0x300 one cycle later.
REQ-040 Async reset mid-stream: count=2, assert rst=0 between clock edges -> outputs zero immediately; after release, push 0x400 -> out_pc=0x400 next cycle.
